cyborg_gray_coarse_quant: RTL and testbench
===========================================

Name: cyborg_gray_coarse_quant

Overview:
- Parametrised, multi-channel successor to the single-channel 6-bit Gray coarse quantiser.
- Each channel holds a WIDTH-bit Gray-code counter advanced by a per-channel increment strobe.
- On a common sample strobe, all channels are snapshotted together. The block outputs each snapshot (Gray or binary selectable), the binary first difference against the previous snapshot, and a per-channel wrap/overflow flag.
- Sits between the CCO edge-qualification logic and the fine-quantiser combiner in the ADC back end.

Parameters:
- WIDTH, 6, counter/snapshot width per channel in bits (legal 2..16).
- CHANNELS, 2, number of independent counter channels (legal 1..16).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- inc  input  CHANNELS  per-channel increment strobe, sampled each clk edge.
- sample  input  1  common snapshot strobe, sampled each clk edge.
- bin_mode  input  1  0: code_out carries Gray snapshots; 1: binary-decoded snapshots.
- code_out  output  CHANNELS*WIDTH  snapshot per channel; channel c occupies bits [c*WIDTH +: WIDTH].
- diff_out  output  CHANNELS*WIDTH  binary count difference per channel, same packing as code_out.
- overflow  output  CHANNELS  per-channel flag: the interval held at least 2^WIDTH increments.
- valid  output  1  one-cycle pulse qualifying code_out, diff_out and overflow.

Behaviour:
- Reset: synchronous, active-high, and it dominates inc and sample in the same cycle. On the next clk edge the following all clear to 0:
  - Gray counters, previous-snapshot registers and interval event counters;
  - code_out, diff_out, overflow and valid.
- Reset asserted mid-operation discards the current interval. No valid is issued for it.
- Counter advance:
  - inc[c]=1 at an edge: Gray counter c moves to the next reflected-binary Gray code.
  - All-ones binary (Gray 100..0) wraps to 0.
  - inc[c]=0: counter holds.
- Snapshot semantics: sample=1 at edge t captures each counter's value before that edge's increment. An inc[c] in the same cycle as sample is counted in the following interval.
- Outputs at edge t (latency one clk from sample to valid):
  - valid=1 for exactly one cycle.
  - code_out[c] = Gray snapshot when bin_mode=0, or its binary decode when bin_mode=1. bin_mode is sampled at the sample edge.
  - diff_out[c] = (bin(snapshot) - bin(previous snapshot)) mod 2^WIDTH, always binary.
  - The previous-snapshot register then updates to the new snapshot.
  - The first sample after reset differences against 0.
- Overflow:
  - Each channel has a (WIDTH+1)-bit event counter that saturates at 2^WIDTH.
  - On a sample edge, overflow[c] = (event count >= 2^WIDTH), and the event counter reloads to inc[c].
  - Otherwise the event counter increments on inc[c].
  - When overflow[c]=1, diff_out[c] is the modulo residue, unchanged.
- Between samples, code_out, diff_out and overflow hold their last values; valid=0.
- sample high on consecutive cycles: each edge is an independent snapshot, and valid stays high for each. An interval with no increments gives diff 0, overflow 0.
- Channels are fully independent; only sample, bin_mode, reset and valid are shared.
- Gray-to-binary decode is combinational prefix XOR. Only the snapshot path needs it; the counter itself stays in Gray.

Test Plan (WIDTH=6, CHANNELS=2):
- Reset, then 5 inc[0] pulses, 0 inc[1], sample, bin_mode=0:
  - next cycle valid=1;
  - ch0 code_out=000111, diff_out=5, overflow=0;
  - ch1 code_out=000000, diff_out=0.
- Repeat with bin_mode=1: ch0 code_out=000101.
- 63 increments on ch0, then sample: code_out=100000, diff_out=63, overflow=0.
- The next interval has 1 increment: code_out=000000 (wrap), diff_out=1, overflow=0.
- 70 increments on ch1, then sample: code_out=000101 (count 6), diff_out=6, overflow=1.
- A following interval of exactly 64 increments: diff_out=0, overflow=1.
- 3 increments on ch0, then inc[0] and sample in the same cycle, then sample with no further increments:
  - first valid gives diff_out=3;
  - second valid gives diff_out=1.
- 10 increments on ch0, reset asserted together with sample:
  - no valid pulse;
  - all outputs 0;
  - 2 further increments then sample gives diff_out=2.

Source files
------------

// File: rtl/cyborg_gray_coarse_quant.sv
// cyborg_gray_coarse_quant
//   Multi-channel Gray coarse quantiser. Each channel runs a WIDTH-bit Gray
//   counter advanced by inc[c]. On a common sample strobe every channel is
//   snapshotted at once, and the block reports:
//     - the snapshot, in Gray or binary form;
//     - the binary difference from the previous snapshot;
//     - a per-channel overflow flag.
//   valid is a one-cycle qualifier for those outputs.
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset, dominates inc/sample
//   inc       [CHANNELS] per-channel increment strobe
//   sample    common snapshot strobe
//   bin_mode  0: code_out is Gray, 1: code_out is binary (sampled with sample)
//   code_out  [CHANNELS*WIDTH] snapshot, channel c at [c*WIDTH +: WIDTH]
//   diff_out  [CHANNELS*WIDTH] (snap - prev_snap) mod 2^WIDTH, binary
//   overflow  [CHANNELS] interval held >= 2^WIDTH increments
//   valid     one-cycle pulse, one clk after sample

// Per-channel counter, snapshot and interval accounting.
module cgcq_lane #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         sample_i,
  input  logic         bin_mode_i,
  output logic [W-1:0] code_o,
  output logic [W-1:0] diff_o,
  output logic         ovf_o
);
  logic [W-1:0] gray_q, gray_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W:0]   evt_q, evt_d;
  logic [W-1:0] code_q, code_d;
  logic [W-1:0] diff_q, diff_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] snap_bin, cnt_nxt;

  // Prefix XOR from the MSB down.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    snap_bin = g2b(gray_q);
    // Step in binary and re-encode. The all-ones code wraps to 0 naturally.
    cnt_nxt  = snap_bin + {{(W-1){1'b0}}, 1'b1};
    gray_d   = inc_i ? (cnt_nxt ^ (cnt_nxt >> 1)) : gray_q;
    prev_d   = prev_q;
    code_d   = code_q;
    diff_d   = diff_q;
    ovf_d    = ovf_q;
    if (sample_i) begin
      // The snapshot is the pre-increment value. A same-cycle inc opens the
      // next interval's event count.
      code_d = bin_mode_i ? snap_bin : gray_q;
      diff_d = snap_bin - prev_q;
      prev_d = snap_bin;
      ovf_d  = evt_q[W];
      evt_d  = {{W{1'b0}}, inc_i};
    end else if (inc_i && !evt_q[W]) begin
      // Saturate at 2^W. Once the MSB is set, the interval has overflowed.
      evt_d  = evt_q + {{W{1'b0}}, 1'b1};
    end else begin
      evt_d  = evt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gray_q <= '0;
      prev_q <= '0;
      evt_q  <= '0;
      code_q <= '0;
      diff_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      gray_q <= gray_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
      code_q <= code_d;
      diff_q <= diff_d;
      ovf_q  <= ovf_d;
    end
  end

  assign code_o = code_q;
  assign diff_o = diff_q;
  assign ovf_o  = ovf_q;
endmodule

module cyborg_gray_coarse_quant #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       inc,
  input  logic                      sample,
  input  logic                      bin_mode,
  output logic [CHANNELS*WIDTH-1:0] code_out,
  output logic [CHANNELS*WIDTH-1:0] diff_out,
  output logic [CHANNELS-1:0]       overflow,
  output logic                      valid
);
  logic [CHANNELS-1:0][WIDTH-1:0] code_w, diff_w;
  logic [1:0]                     vld_pipe;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    cgcq_lane #(.W(WIDTH)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (inc[c]),
      .sample_i   (sample),
      .bin_mode_i (bin_mode),
      .code_o     (code_w[c]),
      .diff_o     (diff_w[c]),
      .ovf_o      (overflow[c])
    );
  end

  // A reset in the sample cycle discards the interval, so no valid is issued.
  assign vld_pipe[0] = sample & ~reset;

  always_ff @(posedge clk) begin
    if (reset) vld_pipe[1] <= 1'b0;
    else       vld_pipe[1] <= vld_pipe[0];
  end

  assign code_out = code_w;
  assign diff_out = diff_w;
  assign valid    = vld_pipe[1];
endmodule

// File: tb/tb_cyborg_gray_coarse_quant.sv
module tb_cyborg_gray_coarse_quant;
  localparam int W  = 6;
  localparam int CH = 2;
  localparam int M  = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, sample, bin_mode, valid;
  logic [CH-1:0]     inc, overflow;
  logic [CH*W-1:0]   code_out, diff_out;

  cyborg_gray_coarse_quant #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .inc(inc), .sample(sample), .bin_mode(bin_mode),
    .code_out(code_out), .diff_out(diff_out), .overflow(overflow), .valid(valid)
  );

  typedef struct packed {
    logic [CH-1:0][W-1:0] code;
    logic [CH-1:0][W-1:0] diff;
    logic [CH-1:0]        ovf;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   vec = 0, bad = 0;
  int   cnt[CH], prv[CH], ev[CH];
  bit   mon_en = 0;

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  // The reference model works on plain integer counts. Gray form is n^(n>>1).
  task automatic step(input logic [CH-1:0] i, input logic s, input logic b, input logic r);
    exp_t e;
    inc = i; sample = s; bin_mode = b; reset = r;
    @(posedge clk);
    if (r) begin
      for (int c = 0; c < CH; c++) begin cnt[c] = 0; prv[c] = 0; ev[c] = 0; end
      last = '0;
    end else begin
      if (s) begin
        for (int c = 0; c < CH; c++) begin
          e.code[c] = b ? W'(cnt[c]) : W'(cnt[c] ^ (cnt[c] >> 1));
          e.diff[c] = W'((cnt[c] - prv[c]) & M);
          e.ovf[c]  = (ev[c] >= (1 << W));
          prv[c] = cnt[c];
          ev[c]  = int'(i[c]);
        end
        q.push_back(e);
      end else begin
        for (int c = 0; c < CH; c++) ev[c] += int'(i[c]);
      end
      for (int c = 0; c < CH; c++) cnt[c] = (cnt[c] + int'(i[c])) & M;
    end
    #1;
  endtask

  task automatic run(input int n, input logic [CH-1:0] i);
    for (int k = 0; k < n; k++) step(i, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pop on valid. Otherwise the outputs must hold their last values.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        if (q.size() == 0) check("unexpected_valid", 64'(valid), 64'd0);
        else begin
          last = q.pop_front();
          check("code_out", 64'(code_out), 64'(last.code));
          check("diff_out", 64'(diff_out), 64'(last.diff));
          check("overflow", 64'(overflow), 64'(last.ovf));
        end
      end else begin
        check("missing_valid", 64'(q.size()), 64'd0);
        check("hold_code", 64'(code_out), 64'(last.code));
        check("hold_diff", 64'(diff_out), 64'(last.diff));
        check("hold_ovf",  64'(overflow), 64'(last.ovf));
      end
    end
  end

  initial begin
    inc = '0; sample = 0; bin_mode = 0; reset = 1;
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);
    mon_en = 1;
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_code",  64'(code_out), 64'd0);
    check("reset_diff",  64'(diff_out), 64'd0);
    check("reset_ovf",   64'(overflow), 64'd0);

    // 5 increments on ch0, Gray snapshot then binary snapshot
    run(5, 2'b01); step('0, 1, 0, 0); step('0, 0, 0, 0);
    check("tp_gray5", 64'(code_out[W-1:0]), 64'b000111);
    step('0, 0, 0, 1);
    run(5, 2'b01); step('0, 1, 1, 0); step('0, 0, 0, 0);
    check("tp_bin5", 64'(code_out[W-1:0]), 64'b000101);

    // 63 increments, then 1 increment to wrap
    step('0, 0, 0, 1);
    run(63, 2'b01); step('0, 1, 0, 0); step('0, 0, 0, 0);
    check("tp_63", 64'(code_out[W-1:0]), 64'b100000);
    run(1, 2'b01); step('0, 1, 0, 0); step('0, 0, 0, 0);
    check("tp_wrap", 64'(diff_out[W-1:0]), 64'd1);

    // 70 increments on ch1, overflow; then exactly 64
    step('0, 0, 0, 1);
    run(70, 2'b10); step('0, 1, 0, 0); step('0, 0, 0, 0);
    check("tp_ovf70", 64'(overflow[1]), 64'd1);
    run(64, 2'b10); step('0, 1, 0, 0); step('0, 0, 0, 0);
    check("tp_ovf64", 64'(overflow[1]), 64'd1);

    // inc together with sample, then back-to-back samples
    run(3, 2'b01); step(2'b01, 1, 0, 0); step('0, 1, 0, 0); step('0, 1, 0, 0);
    run(2, '0);

    // reset together with sample discards the interval
    run(10, 2'b01); step('0, 1, 0, 1); run(2, 2'b01);
    step('0, 1, 0, 0); step('0, 0, 0, 0);
    check("tp_post_reset", 64'(diff_out[W-1:0]), 64'd2);

    // random traffic, short intervals
    for (int k = 0; k < 3000; k++)
      step(CH'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom),
           ($urandom_range(0, 299) == 0));
    // random traffic, long intervals that cross the overflow threshold
    for (int k = 0; k < 3000; k++)
      step(CH'($urandom | $urandom), ($urandom_range(0, 119) == 0), 1'($urandom), 1'b0);

    run(3, '0);
    mon_en = 0;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
